// File: rtl/adder_pipe.sv
// adder_pipe - pipelined integer adder/subtractor with valid/ready handshake.
//
// The WIDTH-bit add is cut into STAGES equal slices of W = WIDTH/STAGES bits.
// Stage k adds slice k of a and b_eff together with the carry produced by
// stage k-1, so each register stage only sees a W-bit carry chain.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   in_valid   a/b/sub valid this cycle
//   in_ready   block accepts operands this cycle (low only while stalled)
//   a, b       operands, WIDTH bits
//   sub        0: res = a + b, 1: res = a - b
//   out_valid  res/flags valid
//   out_ready  consumer takes the result this cycle
//   res        sum/difference modulo 2^WIDTH
//   carry      carry out of the MSB (subtract: 1 = no borrow)
//   overflow   two's-complement signed overflow
//   zero       res == 0
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int W = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > 8) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $error("adder_pipe: STAGES must be 1..8 and divide WIDTH");
  end

  // The whole pipe moves in lock-step: it either advances everywhere or
  // holds everywhere. Bubbles travel with the pipe and are not collapsed.
  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Subtraction as a + ~b + 1; the +1 enters as the carry into slice 0.
  logic [WIDTH-1:0] b_eff;
  assign b_eff = sub ? ~b : b;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * W;

    // Stage inputs: operand bits from LO upward, finished result bits below LO.
    logic [WIDTH-1:LO] a_in;
    logic [WIDTH-1:LO] b_in;
    logic              c_in;
    logic              v_in;
    logic [W:0]        slice_sum;
    logic [LO+W-1:0]   s_out;

    if (gi == 0) begin : g_first
      assign a_in  = a;
      assign b_in  = b_eff;
      assign c_in  = sub;
      // Only looked at while the pipe advances, i.e. while in_ready is high.
      assign v_in  = in_valid;
      assign s_out = slice_sum[W-1:0];
    end else begin : g_next
      assign a_in  = g_stage[gi-1].g_mid.a_reg;
      assign b_in  = g_stage[gi-1].g_mid.b_reg;
      assign c_in  = g_stage[gi-1].g_mid.c_reg;
      assign v_in  = g_stage[gi-1].g_mid.v_reg;
      assign s_out = {slice_sum[W-1:0], g_stage[gi-1].g_mid.s_reg};
    end

    assign slice_sum = {1'b0, a_in[LO+W-1:LO]} + {1'b0, b_in[LO+W-1:LO]}
                     + {{W{1'b0}}, c_in};

    if (gi < STAGES - 1) begin : g_mid
      // Only the slices still to be added are carried forward.
      logic [WIDTH-1:LO+W] a_reg;
      logic [WIDTH-1:LO+W] b_reg;
      logic [LO+W-1:0]     s_reg;
      logic                c_reg;
      logic                v_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          v_reg <= 1'b0;
        end else if (!stall) begin
          v_reg <= v_in;
          if (v_in) begin
            a_reg <= a_in[WIDTH-1:LO+W];
            b_reg <= b_in[WIDTH-1:LO+W];
            s_reg <= s_out;
            c_reg <= slice_sum[W];
          end
        end
      end
    end else begin : g_last
      // Final slice: a_in/b_in hold exactly the top slice, so their MSBs are
      // the operand sign bits needed for the overflow flag.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          res       <= '0;
          carry     <= 1'b0;
          overflow  <= 1'b0;
          zero      <= 1'b0;
        end else if (!stall) begin
          out_valid <= v_in;
          // Result and flags only change when a real op arrives.
          if (v_in) begin
            res      <= s_out;
            carry    <= slice_sum[W];
            overflow <= (a_in[WIDTH-1] == b_in[WIDTH-1]) &&
                        (s_out[WIDTH-1] != a_in[WIDTH-1]);
            zero     <= ~|s_out;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe - directed checks on a 32-bit/2-stage adder_pipe plus a
// reference-model run on a 64-bit/4-stage instance.
module tb_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // 32-bit, 2-stage instance
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res;
  logic        carry, overflow, zero;

  adder_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .carry(carry), .overflow(overflow), .zero(zero)
  );

  // 64-bit, 4-stage instance
  logic        r_in_valid = 1'b0;
  logic        r_in_ready;
  logic [63:0] r_a = '0;
  logic [63:0] r_b = '0;
  logic        r_sub = 1'b0;
  logic        r_out_valid;
  logic        r_out_ready = 1'b1;
  logic [63:0] r_res;
  logic        r_carry, r_overflow, r_zero;

  adder_pipe #(.WIDTH(64), .STAGES(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .a(r_a), .b(r_b), .sub(r_sub), .out_valid(r_out_valid), .out_ready(r_out_ready),
    .res(r_res), .carry(r_carry), .overflow(r_overflow), .zero(r_zero)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One op through the 32-bit pipe with the consumer always ready.
  task automatic do_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                       input logic isub, input logic [31:0] er, input logic ec,
                       input logic eo, input logic ez);
    int lat;
    a = ia; b = ib; sub = isub; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    $display("%s: a=%h b=%h sub=%0d -> res=%h c=%0d v=%0d z=%0d lat=%0d",
             tag, ia, ib, isub, res, carry, overflow, zero, lat);
    check_eq({tag, "_lat"}, lat, 2);
    check_eq({tag, "_res"}, res, er);
    check_eq({tag, "_carry"}, carry, ec);
    check_eq({tag, "_ovf"}, overflow, eo);
    check_eq({tag, "_zero"}, zero, ez);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int n_in, n_out, stalls;
    logic [31:0] exp_s;
    logic [66:0] exp_q[$];
    int acc_q[$];
    logic [66:0] e;
    int t, sent;
    logic [63:0] ra, rb, beff;
    logic [64:0] full;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_res", res, 0);
    check_eq("rst_flags", {carry, overflow, zero}, 0);
    check_eq("rst64_out_valid", r_out_valid, 0);
    rst = 1'b0;
    tick();
    check_eq("rst_in_ready", in_ready, 1);

    // Directed single ops
    do_op("ovf_add",   32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    do_op("wrap_add",  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    do_op("neg_sub",   32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    do_op("ovf_sub",   32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    do_op("slice_cy",  32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
    do_op("zero_sub",  32'h00000003, 32'h00000003, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);

    // Stream of 10 back-to-back ops with a 3-cycle consumer stall
    n_in = 0; n_out = 0; stalls = 0;
    for (int cyc = 0; cyc < 60 && n_out < 10; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid  = (n_in < 10);
      a = 32'(n_in); b = 32'(n_in << 16); sub = 1'b0;
      #1;
      if (out_valid && !out_ready) begin
        stalls++;
        check_eq("stall_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        exp_s = 32'(n_out + (n_out << 16));
        $display("stream[%0d]: res=%h", n_out, res);
        check_eq("stream_res", res, exp_s);
        n_out++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) n_in++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_eq("stream_count", n_out, 10);
    check_eq("stream_stalls", stalls, 3);
    check_eq("stream_no_dup", out_valid, 0);

    // Reset with two ops in flight
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'd1; b = 32'd2; sub = 1'b0;
    tick();
    a = 32'd3; b = 32'd4;
    tick();
    check_eq("flight_valid", out_valid, 1);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("flush_valid", out_valid, 0);
    check_eq("flush_res", res, 0);
    check_eq("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("flush_quiet", out_valid, 0);
    end
    do_op("after_rst", 32'd9, 32'd6, 1'b1, 32'd3, 1'b1, 1'b0, 1'b0);

    // 64-bit / 4-stage against a reference model; phase 0 never stalls
    // and checks latency, phase 1 randomises out_ready.
    for (int ph = 0; ph < 2; ph++) begin
      sent = 0;
      for (int cyc = 0; cyc < 4000 && (sent < 300 || exp_q.size() > 0); cyc++) begin
        r_out_ready = (ph == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (!r_in_valid && sent < 300 && $urandom_range(0, 3) != 0) begin
          ra = {$urandom, $urandom};
          rb = {$urandom, $urandom};
          case ($urandom_range(0, 7))
            0: rb = ~ra;
            1: rb = ra;
            2: ra = 64'h7FFFFFFFFFFFFFFF;
            3: ra = 64'h8000000000000000;
            default: ;
          endcase
          r_a = ra; r_b = rb; r_sub = 1'($urandom_range(0, 1));
          r_in_valid = 1'b1;
        end
        #1;
        if (r_out_valid && r_out_ready) begin
          check_eq("r_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = acc_q.pop_front();
            $display("r64 ph%0d: res=%h c=%0d v=%0d z=%0d", ph, r_res, r_carry, r_overflow, r_zero);
            check_eq("r_res", r_res, e[63:0]);
            check_eq("r_carry", r_carry, e[64]);
            check_eq("r_ovf", r_overflow, e[65]);
            check_eq("r_zero", r_zero, e[66]);
            if (ph == 0) check_eq("r_latency", edge_cnt - t, 4);
          end
        end
        acc = r_in_valid && r_in_ready;
        if (acc) begin
          beff = r_sub ? ~r_b : r_b;
          full = {1'b0, r_a} + {1'b0, beff} + {64'b0, r_sub};
          exp_q.push_back({(full[63:0] == 64'd0), (r_a[63] == beff[63]) && (full[63] != r_a[63]),
                           full[64], full[63:0]});
          acc_q.push_back(edge_cnt);
          sent++;
        end
        tick();
        if (acc) r_in_valid = 1'b0;
      end
      check_eq("r_sent", sent, 300);
      check_eq("r_drained", exp_q.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
